// File: rtl/assoc_pkg.sv
// Shared definitions for the assoc_* associative-search family:
// FSM state encoding and the helpers that derive counter/index widths.
package assoc_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Bits needed to hold every value 0..max_count inclusive.
    function automatic int count_width(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

    // Bits needed to address n items (0..n-1), never narrower than 1.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/assoc_popcount.sv
// Combinational population count of one BITWIDTH-bit chunk.
module assoc_popcount
    import assoc_pkg::*;
#(
    parameter  int BITWIDTH = 5,
    localparam int POP_W    = count_width(BITWIDTH)
) (
    input  logic [BITWIDTH-1:0] i_bits,
    output logic [POP_W-1:0]    o_count
);

    always_comb begin
        // NOTE: blocking '=' is required here: each loop iteration must see the sum built so far.
        o_count = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            o_count = o_count + POP_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/assoc_match_accum.sv
// Sequential associative search: accumulates AND-popcount overlap per class over
// NUM_CHUNKS beats, then scans one class per cycle for the best match.
module assoc_match_accum
    import assoc_pkg::*;
#(
    parameter  int BITWIDTH    = 5,
    parameter  int NUM_CLASSES = 26,
    parameter  int NUM_CHUNKS  = 4,
    localparam int CNT_W       = count_width(BITWIDTH * NUM_CHUNKS),
    localparam int IDX_W       = index_width(NUM_CLASSES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BITWIDTH-1:0]             query_chunk,
    input  logic [NUM_CLASSES*BITWIDTH-1:0] class_chunks,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [IDX_W-1:0]                result_idx,
    output logic [CNT_W-1:0]                result_score,
    output logic                            busy
);

    localparam int POP_W = count_width(BITWIDTH);
    localparam int CHK_W = index_width(NUM_CHUNKS);
    localparam int PTR_W = count_width(NUM_CLASSES);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_acc [NUM_CLASSES];
    logic [CHK_W-1:0] r_chunk_cnt;
    logic [PTR_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_best_idx;
    logic [CNT_W-1:0] r_best_score;
    logic [POP_W-1:0] w_pop [NUM_CLASSES];
    logic             w_accept;
    logic             w_last_beat;
    logic             w_scan_done;
    logic [IDX_W-1:0] w_ptr_idx;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pop
        assoc_popcount #(.BITWIDTH(BITWIDTH)) u_popcount (
            .i_bits  (query_chunk & class_chunks[c*BITWIDTH +: BITWIDTH]),
            .o_count (w_pop[c])
        );
    end

    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = (r_chunk_cnt == CHK_W'(NUM_CHUNKS - 1));
    // The pointer runs one past the last class so the result latch gets its own cycle.
    assign w_scan_done = (r_ptr == PTR_W'(NUM_CLASSES));
    assign w_ptr_idx   = r_ptr[IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && w_last_beat) w_next_state = S_ARGMAX;
            end
            S_ARGMAX: begin
                if (w_scan_done) w_next_state = S_DONE;
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the accumulator array is reset explicitly so an aborted search leaves no residue.
            for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
            r_chunk_cnt  <= '0;
            r_ptr        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            result_idx   <= '0;
            result_score <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int c = 0; c < NUM_CLASSES; c++) r_acc[c] <= '0;
                        r_chunk_cnt <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            r_acc[c] <= r_acc[c] + CNT_W'(w_pop[c]);
                        end
                        if (w_last_beat) begin
                            r_chunk_cnt  <= '0;
                            r_ptr        <= '0;
                            r_best_idx   <= '0;
                            r_best_score <= '0;
                        end else begin
                            r_chunk_cnt <= r_chunk_cnt + CHK_W'(1);
                        end
                    end
                end
                S_ARGMAX: begin
                    if (!w_scan_done) begin
                        // Strict compare keeps the lowest index on ties.
                        if (r_acc[w_ptr_idx] > r_best_score) begin
                            r_best_idx   <= w_ptr_idx;
                            r_best_score <= r_acc[w_ptr_idx];
                        end
                        r_ptr <= r_ptr + PTR_W'(1);
                    end else begin
                        result_idx   <= r_best_idx;
                        result_score <= r_best_score;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_match_accum.sv
// Self-checking bench for assoc_match_accum: directed scenarios plus randomized
// searches, all checked against a score-table model of the search.
module tb_assoc_match_accum;

    localparam int BW    = 5;
    localparam int NC    = 26;
    localparam int NCH   = 4;
    localparam int CNT_W = 5;
    localparam int IDX_W = 5;
    localparam int LAT   = NC + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [BW-1:0]        query_chunk;
    logic [NC*BW-1:0]     class_chunks;
    logic                 result_valid;
    logic                 result_ready;
    logic [IDX_W-1:0]     result_idx;
    logic [CNT_W-1:0]     result_score;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [BW-1:0] q_beats [NCH];
    logic [BW-1:0] c_beats [NCH][NC];

    int exp_new_idx, exp_new_score;
    int exp_held_idx, exp_held_score;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    assoc_match_accum #(.BITWIDTH(BW), .NUM_CLASSES(NC), .NUM_CHUNKS(NCH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .query_chunk  (query_chunk),
        .class_chunks (class_chunks),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_idx   (result_idx),
        .result_score (result_score),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Score table: overlap per class summed over beats; winner is the first class reaching the maximum.
    task automatic model_search(output int idx, output int score);
        int s [NC];
        int best;
        best = 0;
        for (int c = 0; c < NC; c++) begin
            s[c] = 0;
            for (int b = 0; b < NCH; b++) s[c] += $countones(q_beats[b] & c_beats[b][c]);
            if (s[c] > best) best = s[c];
        end
        idx = 0;
        for (int c = NC - 1; c >= 0; c--) if (s[c] == best) idx = c;
        score = best;
    endtask

    function automatic logic [NC*BW-1:0] pack_beat(input int b);
        logic [NC*BW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*BW +: BW] = c_beats[b][c];
        return v;
    endfunction

    function automatic logic [NC*BW-1:0] junk_classes();
        logic [NC*BW-1:0] v;
        for (int c = 0; c < NC; c++) v[c*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    task automatic load_test1();
        for (int b = 0; b < NCH; b++) begin
            q_beats[b] = 5'h1F;
            for (int c = 0; c < NC; c++) c_beats[b][c] = (c == 3) ? 5'h1F : 5'h00;
        end
    endtask

    // Classes 5 and 9 reach 12 with different bit patterns; everyone else reaches 8.
    task automatic load_test2();
        for (int b = 0; b < NCH; b++) begin
            q_beats[b] = 5'h1F;
            for (int c = 0; c < NC; c++) c_beats[b][c] = 5'b10001;
            c_beats[b][5] = (b % 2 == 0) ? 5'b00111 : 5'b11100;
            c_beats[b][9] = 5'b01011;
        end
    endtask

    task automatic load_zero();
        for (int b = 0; b < NCH; b++) begin
            q_beats[b] = '0;
            for (int c = 0; c < NC; c++) c_beats[b][c] = '0;
        end
    endtask

    task automatic load_random();
        for (int b = 0; b < NCH; b++) begin
            q_beats[b] = BW'($urandom);
            for (int c = 0; c < NC; c++) c_beats[b][c] = BW'($urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},     in_ready,     0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_result_idx"},   result_idx,   0);
        check({tag, "_result_score"}, result_score, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic send_beats(input int nbeats, input int gap_min, input int gap_max, input bit poke);
        for (int b = 0; b < nbeats; b++) begin
            int gap;
            gap = $urandom_range(gap_max, gap_min);
            repeat (gap) begin
                in_valid     = 1'b0;
                query_chunk  = BW'($urandom);
                class_chunks = junk_classes();
                start        = poke;
                @(posedge clk); #1;
            end
            start        = 1'b0;
            in_valid     = 1'b1;
            query_chunk  = q_beats[b];
            class_chunks = pack_beat(b);
            @(posedge clk); #1;
            in_valid     = 1'b0;
            query_chunk  = BW'($urandom);
            class_chunks = junk_classes();
        end
    endtask

    task automatic run_search(input string tag, input int gap_min, input int gap_max,
                              input int hold_min, input int hold_max, input bit poke,
                              input int lit_idx, input int lit_score);
        int cnt;
        int hold;
        model_search(exp_new_idx, exp_new_score);
        if (lit_idx >= 0) begin
            check({tag, "_model_idx"},   exp_new_idx,   lit_idx);
            check({tag, "_model_score"}, exp_new_score, lit_score);
        end
        do_start();
        send_beats(NCH, gap_min, gap_max, poke);
        cnt = 0;
        while (!result_valid && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_latency"}, cnt, LAT);
        hold = $urandom_range(hold_max, hold_min);
        repeat (hold) begin
            start = poke;
            @(posedge clk); #1;
            check({tag, "_valid_held"}, result_valid, 1);
        end
        start        = poke;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready   = 1'b0;
        start          = 1'b0;
        exp_held_idx   = exp_new_idx;
        exp_held_score = exp_new_score;
        check({tag, "_valid_drop"}, result_valid, 0);
        check({tag, "_busy_drop"},  busy,         0);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, busy, 0);
        if (lit_idx >= 0) begin
            check({tag, "_idx"},   result_idx,   lit_idx);
            check({tag, "_score"}, result_score, lit_score);
        end
    endtask

    task automatic apply_reset(input string tag);
        mon_on   = 1'b0;
        #2 rst   = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_all_zero(tag);
        end
        rst            = 1'b0;
        exp_held_idx   = 0;
        exp_held_score = 0;
        exp_new_idx    = 0;
        exp_new_score  = 0;
        @(posedge clk); #1;
        mon_on = 1'b1;
    endtask

    // Cycle-by-cycle compare against the model's published and pending results.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            if (result_valid) begin
                check("mon_new_idx",   result_idx,   exp_new_idx);
                check("mon_new_score", result_score, exp_new_score);
                check("mon_no_ready_in_done", in_ready, 0);
            end else begin
                check("mon_held_idx",   result_idx,   exp_held_idx);
                check("mon_held_score", result_score, exp_held_score);
            end
            if (!busy) check("mon_idle_in_ready", in_ready, 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        in_valid     = 1'b0;
        result_ready = 1'b0;
        query_chunk  = '0;
        class_chunks = '0;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst            = 1'b0;
        exp_held_idx   = 0;
        exp_held_score = 0;
        @(posedge clk); #1;
        mon_on = 1'b1;

        load_test1();
        run_search("t1", 0, 0, 0, 0, 1'b0, 3, 20);

        load_test2();
        run_search("t2", 0, 0, 0, 0, 1'b0, 5, 12);

        load_zero();
        run_search("t3", 0, 0, 0, 0, 1'b0, 0, 0);

        load_test1();
        run_search("t4", 3, 3, 10, 10, 1'b0, 3, 20);

        load_test1();
        model_search(exp_new_idx, exp_new_score);
        do_start();
        send_beats(2, 0, 0, 1'b0);
        apply_reset("t5_rst");
        load_test2();
        run_search("t5", 0, 0, 0, 0, 1'b0, 5, 12);

        for (int i = 0; i < 3; i++) begin
            in_valid     = 1'b1;
            query_chunk  = 5'h1F;
            class_chunks = junk_classes();
            @(posedge clk); #1;
            check("t6_idle_in_ready", in_ready, 0);
            check("t6_idle_busy",     busy,     0);
        end
        in_valid = 1'b0;
        load_test2();
        run_search("t6", 1, 2, 2, 3, 1'b1, 5, 12);

        for (int i = 0; i < 10; i++) begin
            load_random();
            run_search("rnd", 0, 2, 0, 3, i[0], -1, -1);
        end

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
